// File: rtl/td4_out_uart_tx_if.sv
// td4_out_uart_tx_if: td4 OUT bus in, UART line and status out
interface td4_out_uart_tx_if #(parameter int FIFO_AW = 3);
  logic [7:0] PORT_IN;
  logic TXD;
  logic BUSY;
  logic OVERFLOW;
  logic [FIFO_AW:0] LEVEL;
  modport master (output PORT_IN, input TXD, BUSY, OVERFLOW, LEVEL);
  modport slave (input PORT_IN, output TXD, BUSY, OVERFLOW, LEVEL);
endinterface

// File: rtl/td4_out_uart_tx.sv
// td4_out_uart_tx: queues every change of the td4 OUT port and sends it as a UART 8N1 frame
module td4_out_uart_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int FIFO_AW = 3
) (
  input logic CLOCK,
  input logic RESET,
  td4_out_uart_tx_if.slave bus
);
  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIVISOR);
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [7:0] prev;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW:0] wp;
  logic [FIFO_AW:0] rp;
  logic txd;
  logic overflow;
  logic empty;
  logic full;
  logic push;
  logic wrap;
  always_comb begin
    empty = wp == rp;
    full = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    push = bus.PORT_IN != prev;
    wrap = cnt == CW'(DIVISOR - 1);
    bus.TXD = txd;
    bus.OVERFLOW = overflow;
    bus.LEVEL = wp - rp;
    bus.BUSY = (state != IDLE) || (wp != rp);
  end
  always_ff @(posedge CLOCK)
    if (!RESET && push && !full) mem[wp[FIFO_AW-1:0]] <= bus.PORT_IN;
  // full is judged before the edge, so a same-edge pop never rescues a push
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      prev <= 8'h00;
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      shift <= 8'h00;
      txd <= 1'b1;
    end else begin
      prev <= bus.PORT_IN;
      if (push && !full) wp <= wp + 1'b1;
      if (push && full) overflow <= 1'b1;
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (!empty) begin
          shift <= mem[rp[FIFO_AW-1:0]];
          rp <= rp + 1'b1;
          txd <= 1'b0;
          state <= START;
        end
        START: if (wrap) begin
          txd <= shift[0];
          idx <= 3'd0;
          state <= DATA;
        end
        DATA: if (wrap) begin
          if (idx == 3'd7) begin
            txd <= 1'b1;
            state <= STOP;
          end else begin
            shift <= shift >> 1;
            txd <= shift[1];
            idx <= idx + 1'b1;
          end
        end
        STOP: if (wrap) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_td4_out_uart_tx.sv
// tb_td4_out_uart_tx: directed checks of change detect, FIFO, overflow and UART framing
module tb_td4_out_uart_tx;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int passed = 0;
  int total = 0;
  int fails = 0;
  int nstarts = 0;
  logic [8:0] rxq [$];
  td4_out_uart_tx_if #(.FIFO_AW(3)) bus ();
  td4_out_uart_tx #(.CLK_HZ(1000), .BAUD(250), .FIFO_AW(3)) dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));
  always #5 CLOCK = ~CLOCK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // independent 8N1 receiver, samples mid-bit at DIVISOR=4
  int mcyc = 0;
  logic mact = 1'b0;
  logic mok = 1'b1;
  logic [7:0] mdata = 8'h00;
  always @(negedge CLOCK) begin
    if (!mact) begin
      if (bus.TXD === 1'b0) begin
        mact <= 1'b1;
        mcyc <= 0;
        mok <= 1'b1;
        nstarts <= nstarts + 1;
      end
    end else begin
      mcyc <= mcyc + 1;
      if (mcyc + 1 == 2 && bus.TXD !== 1'b0) mok <= 1'b0;
      if (mcyc + 1 >= 6 && mcyc + 1 <= 34 && (mcyc + 1 - 6) % 4 == 0) mdata[(mcyc + 1 - 6) / 4] <= bus.TXD;
      if (mcyc + 1 == 38) begin
        rxq.push_back({mok && (bus.TXD === 1'b1), mdata});
        mact <= 1'b0;
      end
    end
  end
  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && rxq.size() < n; i++) @(posedge CLOCK);
    chk("frame_timeout", rxq.size() >= n, 1);
    @(negedge CLOCK);
  endtask
  task automatic chk_frame(input string tag, input logic [7:0] exp);
    logic [8:0] got;
    got = 'x;
    if (rxq.size() > 0) got = rxq.pop_front();
    chk(tag, got, {1'b1, exp});
  endtask
  initial begin
    logic [9:0] pat;
    logic [3:0] s;
    int bad;
    int maxlvl;
    int ns;
    bus.PORT_IN = 8'h00;
    repeat (3) @(negedge CLOCK);
    chk("rst_txd", bus.TXD, 1);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    chk("rst_level", bus.LEVEL, 0);
    RESET = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge CLOCK);
      if (bus.TXD !== 1'b1 || bus.BUSY !== 1'b0 || bus.LEVEL !== 4'd0) bad++;
    end
    chk("quiet_cycles", bad, 0);
    chk("quiet_starts", nstarts, 0);
    // single A5 frame, checked cycle by cycle
    bus.PORT_IN = 8'hA5;
    @(negedge CLOCK);
    chk("a5_e0_txd", bus.TXD, 1);
    chk("a5_e0_level", bus.LEVEL, 1);
    chk("a5_e0_busy", bus.BUSY, 1);
    @(negedge CLOCK);
    chk("a5_e1_txd", bus.TXD, 0);
    chk("a5_e1_level", bus.LEVEL, 0);
    pat = 10'b1101001010;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        s[k] = bus.TXD;
        @(negedge CLOCK);
      end
      chk($sformatf("a5_bit%0d", b), s, {4{pat[b]}});
    end
    chk("a5_end_busy", bus.BUSY, 0);
    chk("a5_end_txd", bus.TXD, 1);
    chk_frame("a5_frame", 8'hA5);
    // A5 -> 3C -> A5
    bus.PORT_IN = 8'h3C;
    repeat (50) @(negedge CLOCK);
    bus.PORT_IN = 8'hA5;
    repeat (50) @(negedge CLOCK);
    chk_frame("seq_3c", 8'h3C);
    chk_frame("seq_a5", 8'hA5);
    chk("seq_count", rxq.size(), 0);
    // ten changes on consecutive edges overflow the 8-deep FIFO
    maxlvl = 0;
    for (int i = 0; i < 10; i++) begin
      bus.PORT_IN = 8'(8'h11 * (i + 1));
      @(negedge CLOCK);
      if (int'(bus.LEVEL) > maxlvl) maxlvl = int'(bus.LEVEL);
    end
    chk("burst_level", bus.LEVEL, 8);
    chk("burst_peak", maxlvl, 8);
    chk("burst_ovf", bus.OVERFLOW, 1);
    wait_frames(9, 500);
    for (int i = 0; i < 9; i++) chk_frame($sformatf("burst_%0d", i), 8'(8'h11 * (i + 1)));
    repeat (60) @(negedge CLOCK);
    chk("burst_dropped", rxq.size(), 0);
    chk("burst_idle", bus.BUSY, 0);
    chk("burst_ovf_sticky", bus.OVERFLOW, 1);
    // reset pulse during the data bits aborts the frame
    bus.PORT_IN = 8'h5A;
    repeat (12) @(negedge CLOCK);
    chk("abort_busy_pre", bus.BUSY, 1);
    RESET = 1'b1;
    bus.PORT_IN = 8'h00;
    @(negedge CLOCK);
    chk("abort_txd", bus.TXD, 1);
    chk("abort_level", bus.LEVEL, 0);
    chk("abort_ovf", bus.OVERFLOW, 0);
    chk("abort_busy", bus.BUSY, 0);
    RESET = 1'b0;
    repeat (50) @(negedge CLOCK);
    rxq.delete();
    ns = nstarts;
    bad = 0;
    repeat (60) begin
      @(negedge CLOCK);
      if (bus.TXD !== 1'b1 || bus.BUSY !== 1'b0) bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_starts", nstarts, ns);
    // nonzero port value held through reset is sent once after release
    RESET = 1'b1;
    bus.PORT_IN = 8'h01;
    repeat (3) @(negedge CLOCK);
    chk("r01_txd", bus.TXD, 1);
    chk("r01_level", bus.LEVEL, 0);
    RESET = 1'b0;
    ns = nstarts;
    wait_frames(1, 100);
    chk_frame("r01_frame", 8'h01);
    repeat (60) @(negedge CLOCK);
    chk("r01_once", nstarts - ns, 1);
    chk("r01_idle", bus.BUSY, 0);
    chk("r01_txd_idle", bus.TXD, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
